// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: state encoding, widths and header check.
package imem_loader_pkg;

   localparam int unsigned IMEM_SIZE_DEF = 1024;
   localparam int unsigned LEN_W         = 16;
   localparam int unsigned CNT_W         = 18;
   localparam int unsigned ADDR_W        = 32;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LEN_HI = 3'd1,
      LEN_LO = 3'd2,
      LOAD   = 3'd3,
      DONE   = 3'd4,
      ERROR  = 3'd5
   } state_t;

   // True when an image of n words starting at base ends inside a memory of size bytes.
   function automatic logic hdr_fits(input logic [ADDR_W-1:0] base,
                                     input logic [ADDR_W-1:0] size,
                                     input logic [LEN_W-1:0]  n);
      logic [ADDR_W:0] last;
      last = {1'b0, base} + (ADDR_W+1)'({n, 2'b00});
      return last <= {1'b0, size};
   endfunction

endpackage

// File: rtl/imem_loader.sv
// Streams a length-prefixed program image into instruction memory byte by byte,
// holding the CPU until the whole image has been written.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int unsigned IMSize    = IMEM_SIZE_DEF,
   parameter int unsigned BASE_ADDR = 0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              cpu_hold,
   output logic              done,
   output logic              error
);

   state_t           state;
   logic [7:0]       len_hi;
   logic [CNT_W-1:0] k;
   logic [CNT_W-1:0] k_last;
   logic             hs;
   logic [LEN_W-1:0] n_in;

   assign hs   = in_valid && in_ready;
   assign n_in = {len_hi, in_data};

   // Loader FSM with registered stream, memory and status outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         len_hi    <= 8'd0;
         k         <= '0;
         k_last    <= '0;
         in_ready  <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= 8'd0;
         cpu_hold  <= 1'b1;
         done      <= 1'b0;
         error     <= 1'b0;
      end else begin
         mem_we <= 1'b0;
         case (state)
            IDLE, DONE, ERROR: begin
               if (start) begin
                  state    <= LEN_HI;
                  in_ready <= 1'b1;
                  cpu_hold <= 1'b1;
                  done     <= 1'b0;
                  error    <= 1'b0;
               end
            end
            LEN_HI: begin
               if (hs) begin
                  len_hi <= in_data;
                  state  <= LEN_LO;
               end
            end
            LEN_LO: begin
               if (hs) begin
                  k      <= '0;
                  k_last <= CNT_W'({n_in, 2'b00}) - CNT_W'(1);
                  if (n_in == '0) begin
                     state    <= DONE;
                     in_ready <= 1'b0;
                     done     <= 1'b1;
                     cpu_hold <= 1'b0;
                  end else if (!hdr_fits(ADDR_W'(BASE_ADDR), ADDR_W'(IMSize), n_in)) begin
                     state    <= ERROR;
                     in_ready <= 1'b0;
                     error    <= 1'b1;
                  end else begin
                     state <= LOAD;
                  end
               end
            end
            LOAD: begin
               if (hs) begin
                  mem_we    <= 1'b1;
                  mem_addr  <= ADDR_W'(BASE_ADDR) + ADDR_W'(k);
                  mem_wdata <= in_data;
                  k         <= k + CNT_W'(1);
                  // The final byte's write pulse lands on the first DONE cycle.
                  if (k == k_last) begin
                     state    <= DONE;
                     in_ready <= 1'b0;
                     done     <= 1'b1;
                     cpu_hold <= 1'b0;
                  end
               end
            end
            default: begin
               state    <= IDLE;
               in_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: two instances (base 0 and base 16) against a
// scoreboard of expected writes and a reference memory image.
module tb_imem_loader;

   localparam int unsigned IMS = 1024;
   localparam int unsigned B1  = 16;

   logic        clock = 1'b0;
   logic        reset;
   logic        start0, start1, in_valid;
   logic [7:0]  in_data;
   logic        in_ready0, mem_we0, cpu_hold0, done0, error0;
   logic        in_ready1, mem_we1, cpu_hold1, done1, error1;
   logic [31:0] mem_addr0, mem_addr1;
   logic [7:0]  mem_wdata0, mem_wdata1;

   logic [7:0]  mem0 [IMS];
   logic [7:0]  mem1 [IMS];
   logic [7:0]  ref0 [IMS];
   logic [7:0]  ref1 [IMS];
   logic [7:0]  fixed_img [8];

   typedef struct {
      logic [31:0] a;
      logic [7:0]  d;
   } wr_t;
   wr_t q0[$];
   wr_t q1[$];

   int n_checks = 0;
   int n_pass   = 0;

   imem_loader #(.IMSize(IMS), .BASE_ADDR(0)) u_dut0 (
      .clock(clock), .reset(reset), .start(start0), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready0), .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
      .cpu_hold(cpu_hold0), .done(done0), .error(error0));

   imem_loader #(.IMSize(IMS), .BASE_ADDR(B1)) u_dut1 (
      .clock(clock), .reset(reset), .start(start1), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
      .cpu_hold(cpu_hold1), .done(done1), .error(error1));

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // {in_ready, mem_we, cpu_hold, done, error}
   function automatic logic [4:0] stat(input logic s);
      return s ? {in_ready1, mem_we1, cpu_hold1, done1, error1}
               : {in_ready0, mem_we0, cpu_hold0, done0, error0};
   endfunction

   function automatic logic rdy(input logic s);
      return s ? in_ready1 : in_ready0;
   endfunction

   // Memory model plus scoreboard for each instance's write port.
   always @(negedge clock) begin
      wr_t w;
      if (mem_we0) begin
         if (q0.size() == 0) check("unexpected_wr0", mem_addr0, 32'hFFFF_FFFF);
         else begin
            w = q0.pop_front();
            check("wr0_addr", mem_addr0, w.a);
            check("wr0_data", 32'(mem_wdata0), 32'(w.d));
         end
         if (mem_addr0 < IMS) mem0[mem_addr0[9:0]] = mem_wdata0;
      end
   end

   always @(negedge clock) begin
      wr_t w;
      if (mem_we1) begin
         if (q1.size() == 0) check("unexpected_wr1", mem_addr1, 32'hFFFF_FFFF);
         else begin
            w = q1.pop_front();
            check("wr1_addr", mem_addr1, w.a);
            check("wr1_data", 32'(mem_wdata1), 32'(w.d));
         end
         if (mem_addr1 < IMS) mem1[mem_addr1[9:0]] = mem_wdata1;
      end
   end

   task automatic pulse_start(input logic s);
      @(negedge clock);
      in_valid = 1'b0;
      if (s) start1 = 1'b1; else start0 = 1'b1;
      @(negedge clock);
      start0 = 1'b0;
      start1 = 1'b0;
      check("start_status", 32'(stat(s)), 32'(5'b10100));
   endtask

   task automatic send(input logic s, input logic [7:0] b, input int gap, input logic st);
      int cnt = 0;
      repeat (gap) begin
         @(negedge clock);
         in_valid = 1'b0;
         in_data  = 8'($urandom);
      end
      @(negedge clock);
      in_valid = 1'b1;
      in_data  = b;
      if (st) begin
         if (s) start1 = 1'b1; else start0 = 1'b1;
      end
      while (!rdy(s) && cnt < 100) begin
         @(negedge clock);
         cnt++;
      end
      if (cnt >= 100) check("ready_timeout", 32'(rdy(s)), 32'd1);
      @(posedge clock);
      #1;
      start0   = 1'b0;
      start1   = 1'b0;
      in_valid = 1'b0;
   endtask

   task automatic load(input logic s, input int unsigned n, input int gapmax,
                       input logic mid_start, input logic fixed);
      int unsigned base = s ? B1 : 0;
      int unsigned lim  = (IMS - base) / 4;
      logic [7:0]  b;
      pulse_start(s);
      send(s, 8'(n >> 8), int'($urandom % (gapmax + 1)), 1'b0);
      send(s, 8'(n), int'($urandom % (gapmax + 1)), 1'b0);
      if (n != 0 && n <= lim) begin
         for (int unsigned k = 0; k < 4 * n; k++) begin
            b = fixed ? fixed_img[k % 8] : 8'($urandom);
            if (s) begin q1.push_back('{a: base + k, d: b}); ref1[base + k] = b; end
            else   begin q0.push_back('{a: base + k, d: b}); ref0[base + k] = b; end
            send(s, b, int'($urandom % (gapmax + 1)), mid_start && ($urandom % 4 == 0));
         end
      end
      @(negedge clock);
      if (n == 0)        check("zero_len_status", 32'(stat(s)), 32'(5'b00010));
      else if (n > lim)  check("oversize_status", 32'(stat(s)), 32'(5'b00101));
      else               check("done_status",     32'(stat(s)), 32'(5'b01010));
      @(negedge clock);
      check("pending_writes", 32'(s ? q1.size() : q0.size()), 32'd0);
   endtask

   task automatic image_check(input logic s, input string tag);
      int diffs = 0;
      for (int i = 0; i < int'(IMS); i++)
         if ((s ? mem1[i] : mem0[i]) !== (s ? ref1[i] : ref0[i])) diffs++;
      check(tag, 32'(diffs), 32'd0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int unsigned n;
      int unsigned lim;
      logic        s;
      logic [31:0] fetch;
      fixed_img = '{8'h3C, 8'h01, 8'h00, 8'h10, 8'hAC, 8'h22, 8'h00, 8'h04};
      for (int i = 0; i < int'(IMS); i++) begin
         mem0[i] = 8'd0; mem1[i] = 8'd0; ref0[i] = 8'd0; ref1[i] = 8'd0;
      end
      reset = 1'b1; start0 = 1'b0; start1 = 1'b0; in_valid = 1'b0; in_data = 8'd0;
      repeat (2) @(negedge clock);
      check("reset_status", 32'(stat(1'b0)), 32'(5'b00100));
      check("reset_addr", mem_addr0, 32'd0);
      reset = 1'b0;
      repeat (2) @(negedge clock);
      check("idle_not_ready", 32'(stat(1'b0)), 32'(5'b00100));

      // Basic load with continuous valid, then fetch the second word.
      load(1'b0, 2, 0, 1'b0, 1'b1);
      fetch = {mem0[4], mem0[5], mem0[6], mem0[7]};
      check("fetch_pc4", fetch, 32'hAC22_0004);
      for (int i = 0; i < int'(IMS); i++) mem0[i] = 8'd0;
      load(1'b0, 2, 2, 1'b0, 1'b1);
      image_check(1'b0, "gap_image");
      load(1'b0, 0, 1, 1'b0, 1'b0);
      load(1'b0, 257, 0, 1'b0, 1'b0);
      load(1'b0, 65535, 1, 1'b0, 1'b0);
      load(1'b1, 1, 0, 1'b1, 1'b0);
      load(1'b1, 253, 0, 1'b0, 1'b0);
      load(1'b1, 252, 0, 1'b0, 1'b0);
      load(1'b0, 256, 0, 1'b1, 1'b0);

      for (int it = 0; it < 40; it++) begin
         s   = 1'($urandom % 2);
         lim = (IMS - (s ? B1 : 0)) / 4;
         case ($urandom % 10)
            0:       n = 0;
            1:       n = lim + 1 + ($urandom % 200);
            default: n = 1 + ($urandom % 12);
         endcase
         load(s, n, int'($urandom % 3), 1'($urandom % 2), 1'b0);
      end
      image_check(1'b0, "mem0_image");
      image_check(1'b1, "mem1_image");

      // Reset in the middle of a load: three data bytes land, the rest never do.
      pulse_start(1'b0);
      send(1'b0, 8'h00, 0, 1'b0);
      send(1'b0, 8'h02, 0, 1'b0);
      for (int unsigned k = 0; k < 3; k++) begin
         q0.push_back('{a: k, d: 8'hA0 + 8'(k)});
         ref0[k] = 8'hA0 + 8'(k);
         send(1'b0, 8'hA0 + 8'(k), 0, 1'b0);
      end
      @(negedge clock);
      #2;
      reset = 1'b1;
      #1;
      check("midreset_status0", 32'(stat(1'b0)), 32'(5'b00100));
      check("midreset_addr0", mem_addr0, 32'd0);
      check("midreset_wdata0", 32'(mem_wdata0), 32'd0);
      check("midreset_status1", 32'(stat(1'b1)), 32'(5'b00100));
      @(negedge clock);
      reset = 1'b0;
      repeat (3) @(negedge clock);
      check("post_reset_idle", 32'(stat(1'b0)), 32'(5'b00100));
      check("midreset_pending", 32'(q0.size()), 32'd0);
      image_check(1'b0, "midreset_image");

      load(1'b0, 3, 1, 1'b0, 1'b0);
      image_check(1'b0, "final_image");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
